regfile_bypass_clr: RTL and testbench

Parametrised successor to the CPU datapath register file. It provides two combinational read ports and one write port, and the data width, address width and hard-zero register are all set by parameters.
- Adds asynchronous reset of the whole array.
- Adds write-to-read bypass so a same-cycle read returns the value being written.
- Adds a sequential clear engine that zeroes the array one entry per cycle on request, reporting busy/done and stalling the write port while it runs.
- Sits between decode (RA/RB), execute (BusA/BusB) and writeback (RW/BusW/RegWr).

---
 rtl/datapath_defs.sv | 15 +
 rtl/regfile_bypass_clr_if.sv | 32 +++
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_bypass_clr.sv | 84 ++++++++
 tb/tb_regfile_bypass_clr.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_defs.sv
// Shared datapath constants and clear-engine state encoding.
// Combinational-only definitions; no latency or backpressure of its own.
package datapath_defs;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_REG   = 31;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_bypass_clr_if.sv
// Decode/execute/writeback bundle for the register file: read addresses/data, write port, clear control.
// The register file takes the slave side; the surrounding pipeline takes the master side.
interface regfile_bypass_clr_if
  import datapath_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;
  logic [ADDR_WIDTH-1:0] RW;
  logic [DATA_WIDTH-1:0] BusW;
  logic                  RegWr;
  logic                  ClearReq;
  logic                  ClearBusy;
  logic                  ClearDone;
  logic                  WrStall;

  modport master (
    output RA, RB, RW, BusW, RegWr, ClearReq,
    input  BusA, BusB, ClearBusy, ClearDone, WrStall
  );

  modport slave (
    input  RA, RB, RW, BusW, RegWr, ClearReq,
    output BusA, BusB, ClearBusy, ClearDone, WrStall
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once, one per cycle, then pulses done for one cycle.
// Takes DEPTH cycles in RUN; requests arriving while running are ignored.
module regfile_clear_fsm
  import datapath_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ClearReq,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ClearBusy,
  output logic                  ClearDone
);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (ClearReq) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        // Counter wraps to zero naturally after the last entry.
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = CLR_DONE;
        end
      end
      CLR_DONE: begin
        state_d = ClearReq ? CLR_RUN : CLR_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_en    = (state_q == CLR_RUN);
  assign clr_addr  = cnt_q;
  assign ClearBusy = (state_q == CLR_RUN);
  assign ClearDone = (state_q == CLR_DONE);

endmodule

// File: rtl/regfile_bypass_clr.sv
// Two-read/one-write register file with hard-zero entry, write-to-read bypass and a sequential clear engine.
// Reads are combinational, writes land one cycle later; the clear engine wins over the write port.
module regfile_bypass_clr
  import datapath_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter int BYPASS     = 1
) (
  input logic                Clk,
  input logic                Reset_n,
  regfile_bypass_clr_if.slave bus
);

  localparam int                    DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR    = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clear_busy;
  logic                  clear_done;
  logic                  wr_stall;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  regfile_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ClearReq  (bus.ClearReq),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .ClearBusy (clear_busy),
    .ClearDone (clear_done)
  );

  // A request cycle already stalls writes so the clear never races a late write.
  assign wr_stall  = bus.RegWr & (bus.ClearReq | clear_busy);
  assign wr_commit = bus.RegWr & ~wr_stall & (bus.RW != ZR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem[bus.RW] <= bus.BusW;
    end
  end

  always_comb begin
    rd_a = mem[bus.RA];
    if ((BYPASS != 0) && wr_commit && (bus.RW == bus.RA)) begin
      rd_a = bus.BusW;
    end
    if (bus.RA == ZR) begin
      rd_a = '0;
    end
  end

  always_comb begin
    rd_b = mem[bus.RB];
    if ((BYPASS != 0) && wr_commit && (bus.RW == bus.RB)) begin
      rd_b = bus.BusW;
    end
    if (bus.RB == ZR) begin
      rd_b = '0;
    end
  end

  assign bus.BusA      = rd_a;
  assign bus.BusB      = rd_b;
  assign bus.WrStall   = wr_stall;
  assign bus.ClearBusy = clear_busy;
  assign bus.ClearDone = clear_done;

endmodule

// File: tb/tb_regfile_bypass_clr.sv
// Directed bench for regfile_bypass_clr: a bypassing and a non-bypassing instance share stimulus,
// an array-level model is compared every falling edge, and literal expectations pin the model.
module tb_regfile_bypass_clr;
  import datapath_defs::*;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 31;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  regfile_bypass_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();
  regfile_bypass_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nb_if ();

  regfile_bypass_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(rf_if)
  );

  regfile_bypass_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(0)
  ) dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .bus(nb_if)
  );

  assign nb_if.RA       = rf_if.RA;
  assign nb_if.RB       = rf_if.RB;
  assign nb_if.RW       = rf_if.RW;
  assign nb_if.BusW     = rf_if.BusW;
  assign nb_if.RegWr    = rf_if.RegWr;
  assign nb_if.ClearReq = rf_if.ClearReq;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array contents plus "clearing, next index" and a one-cycle done flag.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  bit            m_done;
  int            m_idx;

  function automatic bit m_stall();
    return rf_if.RegWr && (rf_if.ClearReq || m_busy);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (int'(a) == ZR) return '0;
    if (byp && rf_if.RegWr && !m_stall() && rf_if.RW == a) return rf_if.BusW;
    return m_mem[a];
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
    end else begin
      if (rf_if.RegWr && !m_stall() && int'(rf_if.RW) != ZR) m_mem[rf_if.RW] <= rf_if.BusW;
      if (m_busy) begin
        m_mem[m_idx] <= '0;
        m_idx        <= (m_idx + 1) % DEPTH;
        if (m_idx == DEPTH - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        m_done <= 1'b0;
        if (rf_if.ClearReq) begin
          m_busy <= 1'b1;
          m_idx  <= 0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    check("busA",    rf_if.BusA,      m_read(rf_if.RA, 1'b1));
    check("busB",    rf_if.BusB,      m_read(rf_if.RB, 1'b1));
    check("nb_busA", nb_if.BusA,      m_read(rf_if.RA, 1'b0));
    check("nb_busB", nb_if.BusB,      m_read(rf_if.RB, 1'b0));
    check("busy",    rf_if.ClearBusy, DW'(m_busy));
    check("done",    rf_if.ClearDone, DW'(m_done));
    check("stall",   rf_if.WrStall,   DW'(m_stall()));
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    rf_if.RegWr = 1'b1;
    rf_if.RW    = AW'(a);
    rf_if.BusW  = d;
    cyc();
    rf_if.RegWr = 1'b0;
  endtask

  int busy_n, done_n, done_k, stall_n, seen55;

  initial begin
    rf_if.RA = '0; rf_if.RB = '0; rf_if.RW = '0; rf_if.BusW = '0;
    rf_if.RegWr = 1'b0; rf_if.ClearReq = 1'b0;
    #2 Reset_n = 1'b0;
    smp();
    check("rst_busA", rf_if.BusA, '0);
    check("rst_busy", rf_if.ClearBusy, '0);
    check("rst_done", rf_if.ClearDone, '0);
    cyc();
    Reset_n = 1'b1;
    cyc();

    // Test 1: plain write then read; zero register reads 0.
    wr(3, 64'hDEAD_BEEF_0000_0001);
    rf_if.RA = AW'(3); rf_if.RB = AW'(31);
    smp();
    check("t1_r3", rf_if.BusA, 64'hDEAD_BEEF_0000_0001);
    check("t1_r31", rf_if.BusB, '0);
    cyc();

    // Test 2: writes to the zero register are ignored and never stall.
    rf_if.RegWr = 1'b1; rf_if.RW = AW'(31); rf_if.BusW = '1; rf_if.RA = AW'(31);
    smp();
    check("t2_same", rf_if.BusA, '0);
    check("t2_stall", rf_if.WrStall, '0);
    cyc();
    rf_if.RegWr = 1'b0;
    smp();
    check("t2_next", rf_if.BusA, '0);
    cyc();

    // Test 3: same-cycle bypass on both ports vs. no bypass.
    wr(7, 64'h99);
    rf_if.RegWr = 1'b1; rf_if.RW = AW'(7); rf_if.BusW = 64'h1234;
    rf_if.RA = AW'(7); rf_if.RB = AW'(7);
    smp();
    check("t3_bypA", rf_if.BusA, 64'h1234);
    check("t3_bypB", rf_if.BusB, 64'h1234);
    check("t3_nbA", nb_if.BusA, 64'h99);
    cyc();
    rf_if.RegWr = 1'b0;
    smp();
    check("t3_after", nb_if.BusA, 64'h1234);
    cyc();

    // Test 4: fill, clear, observe progressive zeroing.
    for (int i = 0; i < 31; i++) wr(i, DW'(i + 1));
    busy_n = 0; done_n = 0; done_k = -99;
    for (int k = -1; k < 38; k++) begin
      rf_if.ClearReq = (k == -1);
      rf_if.RA = AW'(5); rf_if.RB = AW'(20);
      smp();
      if (rf_if.ClearBusy) busy_n++;
      if (rf_if.ClearDone) begin done_n++; done_k = k; end
      if (k == 0)  check("t4_r20_k0", rf_if.BusB, 64'd21);
      if (k == 19) check("t4_r20_k19", rf_if.BusB, 64'd21);
      if (k == 3)  check("t4_r5_k3", rf_if.BusA, 64'd6);
      if (k == 10) check("t4_r5_k10", rf_if.BusA, '0);
      cyc();
    end
    check("t4_busy_cycles", DW'(busy_n), 64'd32);
    check("t4_done_pulses", DW'(done_n), 64'd1);
    check("t4_done_cycle", DW'(done_k), 64'd32);
    for (int i = 0; i < DEPTH; i++) begin
      rf_if.RA = AW'(i);
      smp();
      check("t4_zeroed", rf_if.BusA, '0);
      cyc();
    end

    // Test 5: writes during clear are stalled and never forwarded; re-request ignored.
    wr(9, 64'hAA);
    rf_if.RA = AW'(9);
    smp();
    check("t5_r9", rf_if.BusA, 64'hAA);
    cyc();
    busy_n = 0; done_n = 0; stall_n = 0; seen55 = 0;
    for (int k = -1; k < 37; k++) begin
      rf_if.ClearReq = (k == -1) || (k == 10);
      rf_if.RegWr = (k < 32);
      rf_if.RW = AW'(9); rf_if.BusW = 64'h55; rf_if.RA = AW'(9);
      smp();
      if (rf_if.ClearBusy) busy_n++;
      if (rf_if.ClearDone) done_n++;
      if (rf_if.WrStall) stall_n++;
      if (rf_if.BusA == 64'h55) seen55++;
      cyc();
    end
    check("t5_busy_cycles", DW'(busy_n), 64'd32);
    check("t5_done_pulses", DW'(done_n), 64'd1);
    check("t5_stall_cycles", DW'(stall_n), 64'd33);
    check("t5_never_55", DW'(seen55), 64'd0);
    rf_if.RegWr = 1'b0;
    smp();
    check("t5_r9_after", rf_if.BusA, '0);
    cyc();

    // Test 6: reset mid-clear aborts at once with no done pulse.
    wr(25, 64'h25);
    rf_if.RA = AW'(25);
    smp();
    check("t6_r25", rf_if.BusA, 64'h25);
    cyc();
    for (int k = -1; k < 10; k++) begin
      rf_if.ClearReq = (k == -1);
      cyc();
    end
    #1 Reset_n = 1'b0;
    #1;
    check("t6_busy_async", rf_if.ClearBusy, '0);
    check("t6_r25_rst", rf_if.BusA, '0);
    cyc();
    cyc();
    Reset_n = 1'b1;
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (rf_if.ClearDone) done_n++;
      if (rf_if.ClearBusy) busy_n++;
      cyc();
    end
    check("t6_no_done", DW'(done_n), '0);
    check("t6_no_busy", DW'(busy_n), '0);
    wr(2, 64'h77);
    rf_if.RA = AW'(2);
    smp();
    check("t6_r2", rf_if.BusA, 64'h77);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
